// File: rtl/compression_frame_reader.sv
// Avalon-MM fixed-latency read master that streams a block of words out as one Avalon-ST packet.
// Optional build macro COMPRESSION_FRAME_READER_BSWAP_EN byte-reverses each word as it enters the output FIFO.
module compression_frame_reader #(
  parameter int ADDR_W       = 16,
  parameter int MEM_DEPTH    = 51200,
  parameter int READ_LATENCY = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_address,
  input  logic [15:0]       word_count,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_chipselect,
  output logic              avm_write,
  output logic [3:0]        avm_byteenable,
  output logic              avm_clken,
  input  logic [31:0]       avm_readdata,
  output logic [31:0]       src_data,
  output logic              src_valid,
  input  logic              src_ready,
  output logic              src_startofpacket,
  output logic              src_endofpacket
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(MEM_DEPTH - 1);
  localparam logic [CW:0]       CREDIT_MAX = (CW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_addr;
  logic [15:0]         r_count;
  logic [15:0]         r_issued;
  logic [15:0]         r_push_idx;
  logic                r_busy;
  logic                r_done;
  logic [READ_LATENCY-1:0] r_tag;
  logic [READ_LATENCY-1:0] w_tag_nxt;
  logic [33:0]         r_fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]       r_wr_ptr;
  logic [PW-1:0]       r_rd_ptr;
  logic [CW-1:0]       r_fifo_cnt;

  logic                w_issue;
  logic                w_push;
  logic                w_pop;
  logic                w_src_valid;
  logic [CW-1:0]       w_inflight;
  logic [CW:0]         w_used;
  logic [31:0]         w_push_word;
  logic [33:0]         w_head;

  function automatic logic [CW-1:0] f_tag_count(input logic [READ_LATENCY-1:0] tag);
    logic [CW-1:0] n;
    n = {CW{1'b0}};
    for (int i = 0; i < READ_LATENCY; i++) begin
      n = n + {{(CW-1){1'b0}}, tag[i]};
    end
    return n;
  endfunction

  function automatic logic [31:0] f_bswap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  assign w_inflight  = f_tag_count(r_tag);
  assign w_used      = {1'b0, r_fifo_cnt} + {1'b0, w_inflight};
  assign w_src_valid = (r_fifo_cnt != {CW{1'b0}});
  assign w_pop       = w_src_valid & src_ready;
  assign w_push      = r_tag[READ_LATENCY-1];
  assign w_head      = r_fifo_mem[r_rd_ptr];

`ifdef COMPRESSION_FRAME_READER_BSWAP_EN
  assign w_push_word = f_bswap(avm_readdata);
`else
  assign w_push_word = avm_readdata;
`endif

  // Next-state and read-issue decision; issue only while FIFO slots outnumber committed words.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = (word_count != 16'd0) ? S_ISSUE : S_DONE;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (w_used < CREDIT_MAX) begin
          w_issue     = 1'b1;
          w_state_nxt = ((r_issued + 16'd1) == r_count) ? S_DRAIN : S_ISSUE;
        end else begin
          w_state_nxt = S_ISSUE;
        end
      end
      S_DRAIN: begin
        // Leave as soon as the final word is being accepted so done follows it directly.
        if ((w_inflight == {CW{1'b0}}) &&
            ((r_fifo_cnt == {CW{1'b0}}) ||
             ((r_fifo_cnt == {{(CW-1){1'b0}}, 1'b1}) && w_pop))) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Read-tag pipeline: bit 0 marks a read issued this cycle.
  always_comb begin
    w_tag_nxt    = r_tag << 1;
    w_tag_nxt[0] = w_issue;
  end

  // Control state, address/count tracking and status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_addr     <= {ADDR_W{1'b0}};
      r_count    <= 16'd0;
      r_issued   <= 16'd0;
      r_push_idx <= 16'd0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_tag      <= {READ_LATENCY{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == S_ISSUE) || (w_state_nxt == S_DRAIN);
      r_done  <= (w_state_nxt == S_DONE);
      r_tag   <= w_tag_nxt;
      if ((r_state == S_IDLE) && start) begin
        r_addr   <= base_address;
        r_count  <= word_count;
        r_issued <= 16'd0;
      end else if (w_issue) begin
        r_addr   <= (r_addr == LAST_ADDR) ? {ADDR_W{1'b0}} : (r_addr + {{(ADDR_W-1){1'b0}}, 1'b1});
        r_issued <= r_issued + 16'd1;
      end
      if ((r_state == S_IDLE) && start) begin
        r_push_idx <= 16'd0;
      end else if (w_push) begin
        r_push_idx <= r_push_idx + 16'd1;
      end
    end
  end

  // Output FIFO storing {data, sop, eop}; packet flags are decided at push time.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo_mem[i] <= 34'd0;
      end
      r_wr_ptr   <= {PW{1'b0}};
      r_rd_ptr   <= {PW{1'b0}};
      r_fifo_cnt <= {CW{1'b0}};
    end else begin
      if (w_push) begin
        r_fifo_mem[r_wr_ptr] <= {w_push_word,
                                 (r_push_idx == 16'd0),
                                 (r_push_idx == (r_count - 16'd1))};
        r_wr_ptr <= r_wr_ptr + {{(PW-1){1'b0}}, 1'b1};
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + {{(PW-1){1'b0}}, 1'b1};
      end
      case ({w_push, w_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + {{(CW-1){1'b0}}, 1'b1};
        2'b01:   r_fifo_cnt <= r_fifo_cnt - {{(CW-1){1'b0}}, 1'b1};
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase
    end
  end

  assign busy              = r_busy;
  assign done              = r_done;
  assign avm_address       = r_addr;
  assign avm_chipselect    = w_issue;
  assign avm_write         = 1'b0;
  assign avm_byteenable    = 4'hF;
  assign avm_clken         = 1'b1;
  assign src_valid         = w_src_valid;
  assign src_data          = w_head[33:2];
  assign src_startofpacket = w_src_valid & w_head[1];
  assign src_endofpacket   = w_src_valid & w_head[0];

endmodule

// File: tb/tb_compression_frame_reader.sv
// Randomized bench for compression_frame_reader: a packet model built from (base + k) mod depth
// predicts every address and stream word; directed cases cover latency, backpressure, wrap and reset.
`timescale 1ns/1ps
module tb_compression_frame_reader;

  localparam int ADDR_W    = 16;
  localparam int MEM_DEPTH = 51200;
  localparam int RL        = 1;
  localparam int FD        = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] base_address = 16'd0;
  logic [15:0] word_count = 16'd0;
  logic        busy, done, avm_chipselect, avm_write, avm_clken;
  logic [15:0] avm_address;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_readdata = 32'd0;
  logic [31:0] src_data;
  logic        src_valid, src_sop, src_eop;
  logic        src_ready = 1'b1;

  int n_vec = 0;
  int n_err = 0;
  int ready_mode = 0;
  int cs_cnt = 0;
  int acc_cnt = 0;

  logic [31:0] mem [MEM_DEPTH];
  logic [33:0] exp_q [$];
  logic [15:0] addr_q [$];

  compression_frame_reader #(
    .ADDR_W(ADDR_W), .MEM_DEPTH(MEM_DEPTH), .READ_LATENCY(RL), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_address(base_address),
    .word_count(word_count), .busy(busy), .done(done), .avm_address(avm_address),
    .avm_chipselect(avm_chipselect), .avm_write(avm_write), .avm_byteenable(avm_byteenable),
    .avm_clken(avm_clken), .avm_readdata(avm_readdata), .src_data(src_data),
    .src_valid(src_valid), .src_ready(src_ready), .src_startofpacket(src_sop),
    .src_endofpacket(src_eop)
  );

  always #5 clk = ~clk;

  // On-chip memory with one cycle of read latency.
  always @(posedge clk) begin
    if (avm_chipselect) avm_readdata <= mem[avm_address];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input logic [31:0] w);
`ifdef COMPRESSION_FRAME_READER_BSWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  // Sink ready: held high, held low, or random at ~70%.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       src_ready = 1'b1;
        1:       src_ready = 1'b0;
        default: src_ready = ($urandom_range(0, 9) < 7);
      endcase
    end
  end

  // Monitor: addresses, stream words, credit bound and stall stability.
  initial begin
    logic [34:0] prev_out;
    bit prev_stall;
    prev_stall = 1'b0;
    prev_out = 35'd0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        cs_cnt = 0;
        acc_cnt = 0;
        prev_stall = 1'b0;
        exp_q.delete();
        addr_q.delete();
      end else begin
        if (prev_stall) chk("hold", {src_valid, src_data, src_sop, src_eop}, prev_out);
        if (avm_chipselect) begin
          cs_cnt++;
          chk("credit", 64'(cs_cnt - acc_cnt <= FD), 64'd1);
          if (addr_q.size() == 0) chk("unexp_cs", 64'd1, 64'd0);
          else chk("addr", avm_address, addr_q.pop_front());
        end
        if (src_valid && src_ready) begin
          acc_cnt++;
          if (exp_q.size() == 0) chk("unexp_word", 64'd1, 64'd0);
          else chk("word", {src_data, src_sop, src_eop}, exp_q.pop_front());
        end
        prev_stall = src_valid && !src_ready;
        prev_out = {src_valid, src_data, src_sop, src_eop};
      end
    end
  end

  task automatic check_idle(input string tag);
    chk({tag, "_busy"}, busy, 64'd0);
    chk({tag, "_done"}, done, 64'd0);
    chk({tag, "_cs"}, avm_chipselect, 64'd0);
    chk({tag, "_addr"}, avm_address, 64'd0);
    chk({tag, "_valid"}, src_valid, 64'd0);
    chk({tag, "_sop"}, src_sop, 64'd0);
    chk({tag, "_eop"}, src_eop, 64'd0);
  endtask

  // Queue the expected packet, then pulse start; returns early in the cycle after start is sampled.
  task automatic launch(input logic [15:0] b, input logic [15:0] n);
    for (int k = 0; k < int'(n); k++) begin
      int a;
      a = (int'(b) + k) % MEM_DEPTH;
      addr_q.push_back(16'(a));
      exp_q.push_back({exp_word(mem[a]), 1'(k == 0), 1'(k == int'(n) - 1)});
    end
    @(posedge clk);
    #1;
    base_address = b;
    word_count = n;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound, input int junk_at, input string tag);
    bit seen;
    seen = 1'b0;
    for (int k = 1; k <= bound && !seen; k++) begin
      @(negedge clk);
      if (k == junk_at) begin
        base_address = 16'h7777;
        word_count = 16'd9;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    chk({tag, "_done_seen"}, seen, 64'd1);
    chk({tag, "_words_left"}, exp_q.size(), 64'd0);
    chk({tag, "_addrs_left"}, addr_q.size(), 64'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cs0, a0;
    bit hit;
    for (int i = 0; i < MEM_DEPTH; i++) mem[i] = $urandom;
    for (int i = 16; i < 20; i++) mem[i] = 32'(i);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("rst");
    reset_n = 1'b1;
    @(negedge clk);
    check_idle("idle");
    chk("const_we", {avm_write, avm_byteenable, avm_clken}, {1'b0, 4'hF, 1'b1});

    // Cycle-exact latency: chipselect cycles 1-4, words cycles 3-6, done cycle 7.
    launch(16'h0010, 16'd4);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      chk($sformatf("lat_cs_c%0d", c), avm_chipselect, 64'(c <= 4));
      chk($sformatf("lat_valid_c%0d", c), src_valid, 64'(c >= 3 && c <= 6));
      chk($sformatf("lat_busy_c%0d", c), busy, 64'(c <= 6));
      chk($sformatf("lat_done_c%0d", c), done, 64'(c == 7));
    end
    chk("lat_words_left", exp_q.size(), 64'd0);

    // Sink stalled for the first 10 cycles: only FD reads may be outstanding.
    ready_mode = 1;
    cs0 = cs_cnt;
    launch(16'h0010, 16'd12);
    repeat (10) @(negedge clk);
    #1;
    chk("bp_cs_count", 64'(cs_cnt - cs0), 64'(FD));
    ready_mode = 0;
    wait_done(300, 0, "bp");

    // Address wrap at the end of memory.
    launch(16'd51198, 16'd4);
    wait_done(100, 0, "wrap");

    // Zero-length transfer: done next cycle, no reads, no packet.
    launch(16'h0055, 16'd0);
    @(negedge clk);
    chk("zero_done", done, 64'd1);
    chk("zero_busy", busy, 64'd0);
    chk("zero_cs", avm_chipselect, 64'd0);
    chk("zero_valid", src_valid, 64'd0);
    repeat (3) begin
      @(negedge clk);
      chk("zero_after_done", done, 64'd0);
    end

    // Single word carries both packet flags.
    launch(16'h0200, 16'd1);
    wait_done(50, 0, "one");

    // A start while busy must be ignored.
    ready_mode = 2;
    launch(16'h0400, 16'd20);
    wait_done(500, 5, "busy_start");
    repeat (3) begin
      @(negedge clk);
      chk("busy_start_idle", {busy, avm_chipselect, src_valid}, 64'd0);
    end

    // Reset in the middle of a 100-word transfer.
    ready_mode = 0;
    a0 = acc_cnt;
    launch(16'h0300, 16'd100);
    hit = 1'b0;
    for (int k = 0; k < 400 && !hit; k++) begin
      @(posedge clk);
      #2;
      if (acc_cnt - a0 >= 40) hit = 1'b1;
    end
    chk("mid_reached40", hit, 64'd1);
    reset_n = 1'b0;
    #1;
    check_idle("midrst");
    repeat (2) begin
      @(negedge clk);
      chk("midrst_no_done", done, 64'd0);
    end
    #1;
    reset_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_quiet", {busy, done, avm_chipselect, src_valid}, 64'd0);
    end
    launch(16'h0500, 16'd10);
    wait_done(100, 0, "after_rst");

    // Randomized transfers, some straddling the wrap point.
    ready_mode = 2;
    for (int t = 0; t < 12; t++) begin
      logic [15:0] b, n;
      b = (t % 3 == 0) ? 16'(MEM_DEPTH - $urandom_range(1, 20)) : 16'($urandom_range(0, MEM_DEPTH - 1));
      n = 16'($urandom_range(1, 40));
      launch(b, n);
      wait_done(int'(n) * 20 + 50, 0, $sformatf("rnd%0d", t));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
